image_pipe_mc: RTL

- Next-generation image pipe stage: multi-channel, parametrised pixel processor with frame-synchronous gain/offset, saturation, line-length checking and a valid/busy output buffer.
- Sits between the pixel source and downstream image-pipe consumers.
- Uses the same valid/busy handshake on both sides, so existing busy-driven agents reuse unchanged.

---
 rtl/image_pipe_mc_if.sv | 15 +
 rtl/image_pipe_mc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/image_pipe_mc_if.sv
// Valid/busy pixel stream bundle: data, start-of-frame and end-of-line flags.
// The producer drives the master side; the consumer drives busy back.
interface image_pipe_mc_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 3
) ();
  logic                     valid;
  logic                     busy;
  logic [NUM_CH*DATA_W-1:0] data;
  logic                     sof;
  logic                     eol;

  modport master (output valid, output data, output sof, output eol, input busy);
  modport slave  (input valid, input data, input sof, input eol, output busy);
endinterface

// File: rtl/image_pipe_mc.sv
// Multi-channel gain/offset pixel stage with frame tracking and a credit-managed output FIFO.
// Optional statistics counters are built when IMAGE_PIPE_MC_STATS_EN is defined.
module image_pipe_mc #(
  parameter int DATA_W     = 8,
  parameter int NUM_CH     = 3,
  parameter int GAIN_W     = 8,
  parameter int GAIN_FRAC  = 4,
  parameter int LINE_W     = 16,
  parameter int LINES      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  image_pipe_mc_if.slave      pix_in,
  image_pipe_mc_if.master     pix_out,
  input  logic                cfg_bypass,
  input  logic [GAIN_W-1:0]   cfg_gain,
  input  logic [DATA_W:0]     cfg_offset,
  input  logic                err_clr,
  output logic                err_line,
  output logic                err_sof
`ifdef IMAGE_PIPE_MC_STATS_EN
  ,
  output logic [15:0]         stat_frames,
  output logic [15:0]         stat_drops,
  output logic [15:0]         stat_stall
`endif
);
  localparam int PIX_W  = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int LN_W   = $clog2(LINES + 1);
  localparam int PROD_W = DATA_W + GAIN_W;
  localparam int SUM_W  = PROD_W + 2;
  localparam int PX_W   = NUM_CH * DATA_W;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = AW + 1;
  localparam int OCC_W  = AW + 2;
  localparam int ENT_W  = PX_W + 2;
  localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(LINE_W - 1);
  localparam logic [LN_W-1:0]   LN_LAST   = LN_W'(LINES - 1);
  localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [GAIN_W-1:0] GAIN_ONE  = GAIN_W'(1 << GAIN_FRAC);

  typedef enum logic [0:0] {WAIT_SOF = 1'b0, IN_FRAME = 1'b1} frame_st_t;

  // Scale back, add signed offset, clamp into the unsigned sample range.
  function automatic logic [DATA_W-1:0] sat_ch(input logic [PROD_W-1:0] prod,
                                               input logic [DATA_W:0]   off);
    logic signed [SUM_W-1:0] sum;
    sum = $signed({2'b00, (prod >> GAIN_FRAC)}) +
          $signed({{(SUM_W-DATA_W-1){off[DATA_W]}}, off});
    if (sum[SUM_W-1]) begin
      sat_ch = {DATA_W{1'b0}};
    end else if (sum[SUM_W-2:DATA_W] != {(SUM_W-1-DATA_W){1'b0}}) begin
      sat_ch = {DATA_W{1'b1}};
    end else begin
      sat_ch = sum[DATA_W-1:0];
    end
  endfunction

  frame_st_t           state_r;
  logic [PIX_W-1:0]    pix_cnt_r;
  logic [LN_W-1:0]     line_cnt_r;
  logic [GAIN_W-1:0]   gain_r;
  logic [DATA_W:0]     offset_r;
  logic                bypass_r;
  logic                err_line_r, err_sof_r, in_busy_r;
  logic                s1_valid_r, s1_byp_r, s1_sof_r, s1_eol_r;
  logic [PROD_W-1:0]   s1_prod_r [NUM_CH];
  logic [PX_W-1:0]     s1_raw_r;
  logic [DATA_W:0]     s1_off_r;
  logic                s2_valid_r, s2_sof_r, s2_eol_r;
  logic [PX_W-1:0]     s2_data_r;
  logic [ENT_W-1:0]    fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                out_valid_r;

  logic                in_frame_s, accept_s, restart_s, fwd_s, drop_s;
  logic [PIX_W-1:0]    cur_pix_s;
  logic [LN_W-1:0]     cur_line_s;
  logic                last_pix_s, close_s, line_err_s, sof_err_s, frame_done_s;
  logic [GAIN_W-1:0]   eff_gain_s;
  logic [DATA_W:0]     eff_off_s;
  logic                eff_byp_s, push_s, pop_s;
  logic [PX_W-1:0]     s2_next_s;
  logic [CNT_W-1:0]    cnt_next_s;
  logic [OCC_W-1:0]    occ_next_s;
  logic [ENT_W-1:0]    head_s;

  // Accept/drop decode and line bookkeeping; an sof pixel restarts counting at pixel 0.
  always_comb begin
    case (state_r)
      WAIT_SOF: in_frame_s = 1'b0;
      IN_FRAME: in_frame_s = 1'b1;
      default:  in_frame_s = 1'b0;
    endcase
    accept_s     = pix_in.valid && !in_busy_r;
    restart_s    = accept_s && pix_in.sof;
    fwd_s        = accept_s && (pix_in.sof || in_frame_s);
    drop_s       = accept_s && !fwd_s;
    cur_pix_s    = restart_s ? {PIX_W{1'b0}} : pix_cnt_r;
    cur_line_s   = restart_s ? {LN_W{1'b0}} : line_cnt_r;
    last_pix_s   = (cur_pix_s == PIX_LAST);
    close_s      = fwd_s && (pix_in.eol || last_pix_s);
    line_err_s   = fwd_s && (pix_in.eol != last_pix_s);
    sof_err_s    = drop_s || (restart_s && in_frame_s);
    frame_done_s = close_s && (cur_line_s == LN_LAST);
    eff_gain_s   = restart_s ? cfg_gain   : gain_r;
    eff_off_s    = restart_s ? cfg_offset : offset_r;
    eff_byp_s    = restart_s ? cfg_bypass : bypass_r;
  end

  // Frame FSM, counters, latched config and sticky errors (a new error beats err_clr).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= WAIT_SOF;
      pix_cnt_r  <= {PIX_W{1'b0}};
      line_cnt_r <= {LN_W{1'b0}};
      gain_r     <= GAIN_ONE;
      offset_r   <= {(DATA_W+1){1'b0}};
      bypass_r   <= 1'b0;
      err_line_r <= 1'b0;
      err_sof_r  <= 1'b0;
    end else begin
      if (restart_s) begin
        gain_r   <= cfg_gain;
        offset_r <= cfg_offset;
        bypass_r <= cfg_bypass;
      end
      if (fwd_s) begin
        pix_cnt_r <= close_s ? {PIX_W{1'b0}} : (cur_pix_s + PIX_W'(1'b1));
        if (frame_done_s) begin
          line_cnt_r <= {LN_W{1'b0}};
          state_r    <= WAIT_SOF;
        end else begin
          line_cnt_r <= close_s ? (cur_line_s + LN_W'(1'b1)) : cur_line_s;
          state_r    <= IN_FRAME;
        end
      end
      err_line_r <= line_err_s || (err_line_r && !err_clr);
      err_sof_r  <= sof_err_s  || (err_sof_r  && !err_clr);
    end
  end

  // Stage 1: per-channel multiply with the config in force for this pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_byp_r   <= 1'b0;
      s1_sof_r   <= 1'b0;
      s1_eol_r   <= 1'b0;
      s1_raw_r   <= {PX_W{1'b0}};
      s1_off_r   <= {(DATA_W+1){1'b0}};
      for (int c = 0; c < NUM_CH; c++) s1_prod_r[c] <= {PROD_W{1'b0}};
    end else begin
      s1_valid_r <= fwd_s;
      if (fwd_s) begin
        s1_byp_r <= eff_byp_s;
        s1_sof_r <= pix_in.sof;
        s1_eol_r <= pix_in.eol;
        s1_raw_r <= pix_in.data;
        s1_off_r <= eff_off_s;
        for (int c = 0; c < NUM_CH; c++)
          s1_prod_r[c] <= PROD_W'(pix_in.data[c*DATA_W +: DATA_W]) * PROD_W'(eff_gain_s);
      end
    end
  end

  // Stage 2 combinational result: bypass keeps the raw sample, same latency.
  always_comb begin
    s2_next_s = {PX_W{1'b0}};
    for (int c = 0; c < NUM_CH; c++)
      s2_next_s[c*DATA_W +: DATA_W] = s1_byp_r ? s1_raw_r[c*DATA_W +: DATA_W]
                                               : sat_ch(s1_prod_r[c], s1_off_r);
  end

  // Stage 2 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_data_r  <= {PX_W{1'b0}};
      s2_sof_r   <= 1'b0;
      s2_eol_r   <= 1'b0;
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_data_r  <= s1_valid_r ? s2_next_s : s2_data_r;
      s2_sof_r   <= s1_valid_r ? s1_sof_r  : s2_sof_r;
      s2_eol_r   <= s1_valid_r ? s1_eol_r  : s2_eol_r;
    end
  end

  // Credit: everything in flight must fit in the FIFO, so busy looks at next-cycle occupancy.
  always_comb begin
    push_s     = s2_valid_r;
    pop_s      = out_valid_r && !pix_out.busy;
    cnt_next_s = cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
    occ_next_s = OCC_W'(cnt_next_s) + OCC_W'(fwd_s) + OCC_W'(s1_valid_r);
    head_s     = fifo_mem_r[rd_ptr_r];
  end

  // Output FIFO storage, pointers and registered valid/busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_r[i] <= {ENT_W{1'b0}};
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      cnt_r       <= CNT_ZERO;
      out_valid_r <= 1'b0;
      in_busy_r   <= 1'b1;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= {s2_data_r, s2_sof_r, s2_eol_r};
        wr_ptr_r             <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      cnt_r       <= cnt_next_s;
      out_valid_r <= (cnt_next_s != CNT_ZERO);
      in_busy_r   <= (occ_next_s >= DEPTH_OCC);
    end
  end

  assign pix_in.busy   = in_busy_r;
  assign pix_out.valid = out_valid_r;
  assign pix_out.data  = head_s[ENT_W-1:2];
  assign pix_out.sof   = head_s[1];
  assign pix_out.eol   = head_s[0];
  assign err_line      = err_line_r;
  assign err_sof       = err_sof_r;

`ifdef IMAGE_PIPE_MC_STATS_EN
  logic [15:0] frames_r, drops_r, stall_r;

  // Saturating statistics; err_clr zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_r <= 16'h0000;
      drops_r  <= 16'h0000;
      stall_r  <= 16'h0000;
    end else if (err_clr) begin
      frames_r <= 16'h0000;
      drops_r  <= 16'h0000;
      stall_r  <= 16'h0000;
    end else begin
      frames_r <= (frame_done_s && frames_r != 16'hFFFF) ? frames_r + 16'h0001 : frames_r;
      drops_r  <= (drop_s && drops_r != 16'hFFFF) ? drops_r + 16'h0001 : drops_r;
      stall_r  <= (out_valid_r && pix_out.busy && stall_r != 16'hFFFF) ? stall_r + 16'h0001 : stall_r;
    end
  end

  assign stat_frames = frames_r;
  assign stat_drops  = drops_r;
  assign stat_stall  = stall_r;
`endif
endmodule
